// File: rtl/trace_capture_ctrl_if.sv
// Trace capture bus: config/event inputs toward the capture
// controller, RAM write controls and status back from it.
interface trace_capture_ctrl_if #(
  parameter int EVT_W  = 8,
  parameter int POST_W = 10
);
  logic              cfg_start;
  logic              cfg_stop;
  logic              cfg_clear;
  logic              cfg_trig_en;
  logic [EVT_W-1:0]  cfg_trig_code;
  logic [POST_W-1:0] cfg_post_cnt;
  logic              cfg_oneshot;
  logic              evt_valid;
  logic [EVT_W-1:0]  evt_code;
  logic              trace_clr;
  logic              trace_enb;
  logic              trace_we;
  logic [31:0]       trace_wd;
  logic              trace_mode;
  logic [1:0]        sts_state;
  logic              sts_trig;
  logic              sts_lost;
  logic [15:0]       sts_wr_cnt;

  modport master (
    output cfg_start, cfg_stop, cfg_clear,
    output cfg_trig_en, cfg_trig_code,
    output cfg_post_cnt, cfg_oneshot,
    output evt_valid, evt_code,
    input  trace_clr, trace_enb, trace_we,
    input  trace_wd, trace_mode,
    input  sts_state, sts_trig, sts_lost,
    input  sts_wr_cnt
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_clear,
    input  cfg_trig_en, cfg_trig_code,
    input  cfg_post_cnt, cfg_oneshot,
    input  evt_valid, evt_code,
    output trace_clr, trace_enb, trace_we,
    output trace_wd, trace_mode,
    output sts_state, sts_trig, sts_lost,
    output sts_wr_cnt
  );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: timestamps events and drives the
// 1K x 32 trace RAM with start/stop/clear and trigger FSM.
module trace_capture_ctrl #(
  parameter int EVT_W  = 8,
  parameter int TS_W   = 24,
  parameter int POST_W = 10,
  parameter int DEPTH  = 1024
) (
  input logic user_clk,
  input logic reset_n,
  trace_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TS_W-1:0]   ts_q;
  logic [POST_W-1:0] pc_q;
  logic [POST_W-1:0] pc_d;
  logic              mode_q;
  logic              ten_q;
  logic [EVT_W-1:0]  tcode_q;
  logic              trig_q;
  logic              lost_q;
  logic [15:0]       cnt_q;
  logic              clr_q;
  logic              enb_q;
  logic              we_q;
  logic [31:0]       wd_q;

  logic clear;
  logic stop;
  logic active;
  logic full;
  logic start_ok;
  logic trig_hit;
  logic rec;
  logic we_d;

  always_comb begin
    clear  = bus.cfg_clear;
    stop   = bus.cfg_stop;
    active = (state_q == S_RUN) ||
             (state_q == S_POST);
    // in-flight write counted with trace_we,
    // so the check sees every decided write
    full   = mode_q &&
             (cnt_q >= 16'(DEPTH));
    start_ok = bus.cfg_start && !stop &&
               !clear &&
               ((state_q == S_IDLE) ||
                (state_q == S_DONE));
    trig_hit = (state_q == S_RUN) && ten_q &&
               bus.evt_valid &&
               (bus.evt_code == tcode_q) &&
               !stop && !clear && !full;
    rec = active && !stop && !clear &&
          !full &&
          ((state_q != S_POST) ||
           (pc_q != '0));
    we_d = bus.evt_valid && rec;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (clear) begin
      state_d = S_IDLE;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_ok)
            state_d = S_RUN;
        end
        S_RUN: begin
          if (stop || full) begin
            state_d = S_DONE;
          end else if (trig_hit) begin
            state_d = S_POST;
            pc_d    = bus.cfg_post_cnt;
          end
        end
        S_POST: begin
          if (stop || full ||
              (pc_q == '0))
            state_d = S_DONE;
          else if (bus.evt_valid)
            pc_d = pc_q - 1'b1;
        end
        S_DONE: begin
          if (start_ok)
            state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ts_q    <= clear ? '0 : ts_q + 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= 1'b0;
      ten_q   <= 1'b0;
      tcode_q <= '0;
    end else if (start_ok) begin
      mode_q  <= bus.cfg_oneshot;
      ten_q   <= bus.cfg_trig_en;
      tcode_q <= bus.cfg_trig_code;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q <= 1'b0;
      lost_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (clear || start_ok)
        trig_q <= 1'b0;
      else if (trig_hit)
        trig_q <= 1'b1;
      if (clear || start_ok)
        lost_q <= 1'b0;
      else if (bus.evt_valid && active && full)
        lost_q <= 1'b1;
      if (clear)
        cnt_q <= '0;
      else if (we_d && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_q <= 1'b0;
      enb_q <= 1'b0;
      we_q  <= 1'b0;
      wd_q  <= '0;
    end else begin
      clr_q <= clear;
      enb_q <= active && !clear;
      we_q  <= we_d;
      wd_q  <= {bus.evt_code, ts_q};
    end
  end

  assign bus.trace_clr  = clr_q;
  assign bus.trace_enb  = enb_q;
  assign bus.trace_we   = we_q;
  assign bus.trace_wd   = wd_q;
  assign bus.trace_mode = mode_q;
  assign bus.sts_state  = state_q;
  assign bus.sts_trig   = trig_q;
  assign bus.sts_lost   = lost_q;
  assign bus.sts_wr_cnt = cnt_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl: scoreboard of
// expected trace words, popped on every trace_we.
`timescale 1ns/1ps
module tb_trace_capture_ctrl;

  logic user_clk = 1'b0;
  logic reset_n  = 1'b0;
  always #5 user_clk = ~user_clk;

  trace_capture_ctrl_if #(.EVT_W(8),  .POST_W(10)) bus ();
  trace_capture_ctrl_if #(.EVT_W(24), .POST_W(10)) bus2 ();

  trace_capture_ctrl #(
    .EVT_W(8), .TS_W(24), .POST_W(10), .DEPTH(1024)
  ) dut (
    .user_clk(user_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  trace_capture_ctrl #(
    .EVT_W(24), .TS_W(8), .POST_W(10), .DEPTH(1024)
  ) dut2 (
    .user_clk(user_clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] sbq[$];
  logic [23:0] m_ts;
  logic [7:0]  m_ts2;

  always @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ts  <= '0;
      m_ts2 <= '0;
    end else begin
      m_ts  <= bus.cfg_clear  ? 24'd0 : m_ts + 24'd1;
      m_ts2 <= bus2.cfg_clear ? 8'd0  : m_ts2 + 8'd1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  always @(negedge user_clk) begin
    if (reset_n === 1'b1 && bus.trace_we === 1'b1) begin
      chk("we_enb", {31'd0, bus.trace_enb}, 32'd1);
      if (sbq.size() == 0)
        chk("we_spurious", {31'd0, bus.trace_we}, 32'd0);
      else
        chk("wd", bus.trace_wd, sbq.pop_front());
    end
  end

  task automatic tick();
    @(negedge user_clk);
  endtask

  task automatic ev(input logic [7:0] c, input bit w,
                    input logic [31:0] exp);
    bus.evt_valid = 1'b1;
    bus.evt_code  = c;
    if (w) sbq.push_back(exp);
    tick();
  endtask

  task automatic idle();
    bus.evt_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.cfg_clear = 1'b1;
    tick();
    bus.cfg_clear = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_clr"},  {31'd0, bus.trace_clr},  32'd0);
    chk({p, "_enb"},  {31'd0, bus.trace_enb},  32'd0);
    chk({p, "_we"},   {31'd0, bus.trace_we},   32'd0);
    chk({p, "_wd"},   bus.trace_wd,            32'd0);
    chk({p, "_mode"}, {31'd0, bus.trace_mode}, 32'd0);
    chk({p, "_st"},   {30'd0, bus.sts_state},  32'd0);
    chk({p, "_trig"}, {31'd0, bus.sts_trig},   32'd0);
    chk({p, "_lost"}, {31'd0, bus.sts_lost},   32'd0);
    chk({p, "_cnt"},  {16'd0, bus.sts_wr_cnt}, 32'd0);
  endtask

  initial begin
    logic [7:0] codes [7];
    codes = '{8'h01, 8'h02, 8'hA5, 8'h03,
              8'h04, 8'h05, 8'h06};
    bus.cfg_start = 0; bus.cfg_stop = 0; bus.cfg_clear = 0;
    bus.cfg_trig_en = 0; bus.cfg_trig_code = '0;
    bus.cfg_post_cnt = '0; bus.cfg_oneshot = 0;
    bus.evt_valid = 0; bus.evt_code = '0;
    bus2.cfg_start = 0; bus2.cfg_stop = 0; bus2.cfg_clear = 0;
    bus2.cfg_trig_en = 0; bus2.cfg_trig_code = '0;
    bus2.cfg_post_cnt = '0; bus2.cfg_oneshot = 0;
    bus2.evt_valid = 0; bus2.evt_code = '0;

    repeat (3) tick();
    chk_zero("rst");
    reset_n = 1'b1;
    tick();

    // free recording, codes 1..5 at ts 10..14
    pulse_start();
    chk("p1_run", {30'd0, bus.sts_state}, 32'd1);
    for (int k = 0; k < 100 && m_ts != 24'd10; k++) tick();
    for (int i = 0; i < 5; i++)
      ev(8'(i + 1), 1'b1, {8'(i + 1), 24'(10 + i)});
    idle(); idle();
    chk("p1_cnt", {16'd0, bus.sts_wr_cnt}, 32'd5);
    chk("p1_sb", sbq.size(), 32'd0);

    // trigger A5 with three post-trigger events
    pulse_stop();
    chk("p2_done0", {30'd0, bus.sts_state}, 32'd3);
    bus.cfg_trig_en = 1'b1;
    bus.cfg_trig_code = 8'hA5;
    bus.cfg_post_cnt = 10'd3;
    pulse_start();
    chk("p2_run", {30'd0, bus.sts_state}, 32'd1);
    for (int i = 0; i < 7; i++)
      ev(codes[i], i < 6, {codes[i], m_ts});
    idle();
    chk("p2_done", {30'd0, bus.sts_state}, 32'd3);
    chk("p2_trig", {31'd0, bus.sts_trig}, 32'd1);
    chk("p2_cnt", {16'd0, bus.sts_wr_cnt}, 32'd11);
    chk("p2_sb", sbq.size(), 32'd0);

    // stop coinciding with an event
    bus.cfg_trig_en = 1'b0;
    pulse_start();
    chk("p3_run", {30'd0, bus.sts_state}, 32'd1);
    bus.evt_valid = 1'b1;
    bus.evt_code = 8'h07;
    bus.cfg_stop = 1'b1;
    tick();
    bus.evt_valid = 1'b0;
    bus.cfg_stop = 1'b0;
    chk("p3_we", {31'd0, bus.trace_we}, 32'd0);
    chk("p3_done", {30'd0, bus.sts_state}, 32'd3);
    tick();
    chk("p3_enb", {31'd0, bus.trace_enb}, 32'd0);
    chk("p3_cnt", {16'd0, bus.sts_wr_cnt}, 32'd11);

    // clear and start together, with an event
    bus.cfg_clear = 1'b1;
    bus.cfg_start = 1'b1;
    bus.evt_valid = 1'b1;
    bus.evt_code = 8'h09;
    tick();
    bus.cfg_clear = 1'b0;
    bus.cfg_start = 1'b0;
    bus.evt_valid = 1'b0;
    chk("p4_clr", {31'd0, bus.trace_clr}, 32'd1);
    chk("p4_enb", {31'd0, bus.trace_enb}, 32'd0);
    chk("p4_we", {31'd0, bus.trace_we}, 32'd0);
    chk("p4_idle", {30'd0, bus.sts_state}, 32'd0);
    chk("p4_cnt", {16'd0, bus.sts_wr_cnt}, 32'd0);
    ev(8'h22, 1'b0, 32'd0);
    idle();
    chk("p4_clr1", {31'd0, bus.trace_clr}, 32'd0);
    chk("p4_idle2", {30'd0, bus.sts_state}, 32'd0);

    // one-shot: 1030 events, only 1024 land
    bus.cfg_oneshot = 1'b1;
    pulse_start();
    chk("p5_mode", {31'd0, bus.trace_mode}, 32'd1);
    for (int i = 0; i < 1030; i++)
      ev(8'(i), i < 1024, {8'(i), m_ts});
    idle();
    chk("p5_done", {30'd0, bus.sts_state}, 32'd3);
    chk("p5_lost", {31'd0, bus.sts_lost}, 32'd1);
    chk("p5_cnt", {16'd0, bus.sts_wr_cnt}, 32'd1024);
    chk("p5_enb", {31'd0, bus.trace_enb}, 32'd0);
    chk("p5_sb", sbq.size(), 32'd0);

    // reset asserted while in POST
    pulse_clear();
    bus.cfg_trig_en = 1'b1;
    bus.cfg_trig_code = 8'hA5;
    bus.cfg_post_cnt = 10'd100;
    pulse_start();
    ev(8'h10, 1'b1, {8'h10, m_ts});
    ev(8'hA5, 1'b1, {8'hA5, m_ts});
    ev(8'h11, 1'b1, {8'h11, m_ts});
    idle();
    chk("p6_post", {30'd0, bus.sts_state}, 32'd2);
    chk("p6_enb1", {31'd0, bus.trace_enb}, 32'd1);
    chk("p6_sb", sbq.size(), 32'd0);
    #2 reset_n = 1'b0;
    #1 chk_zero("arst");
    sbq.delete();
    tick();
    reset_n = 1'b1;
    tick();

    // timestamp wrap on an 8-bit timestamp instance
    bus2.cfg_start = 1'b1;
    tick();
    bus2.cfg_start = 1'b0;
    chk("p7_run", {30'd0, bus2.sts_state}, 32'd1);
    for (int k = 0; k < 300 && m_ts2 != 8'hFF; k++) tick();
    bus2.evt_valid = 1'b1;
    bus2.evt_code = 24'h000123;
    tick();
    chk("wrap_we0", {31'd0, bus2.trace_we}, 32'd1);
    chk("wrap_ff", bus2.trace_wd, 32'h000123FF);
    bus2.evt_code = 24'h000456;
    tick();
    bus2.evt_valid = 1'b0;
    chk("wrap_we1", {31'd0, bus2.trace_we}, 32'd1);
    chk("wrap_00", bus2.trace_wd, 32'h00045600);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
